// File: rtl/axi_inst_mem_slave.sv
// axi_inst_mem_slave: AXI4 read-only burst slave over a word-addressed instruction memory.
// A sideband init port preloads words at any time; reads fetch through a registered data path.
// Optional macro INST_MEM_RAND_STALL_EN inserts LFSR-driven one-cycle gaps between beats.
module axi_inst_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_we_i,
  input  logic [31:0] init_addr_i,
  input  logic [31:0] init_data_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_rready_i
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LatInit  = 4'(RD_LATENCY - 1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {StIdle, StLat, StData} state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] next_addr, incr_addr, wrap_mask, fetch_addr;
  logic [1:0]  fetch_resp;
  logic [31:0] fetch_data;
  logic        stall;

  function automatic logic addr_hit(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < MemBytes);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

`ifdef INST_MEM_RAND_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running whenever out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Preload port; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (init_we_i && addr_hit(init_addr_i)) begin
      mem[addr_idx(init_addr_i)] <= init_data_i;
    end
  end

  // Beat address sequencing and the fetch that feeds the registered read data.
  always_comb begin
    incr_addr = addr_q + 32'd4;
    wrap_mask = {22'd0, len_q, 2'b11};
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
    // Beat 0 is fetched on leaving LAT, later beats on the previous beat's handshake.
    fetch_addr = (state_q == StLat) ? addr_q : next_addr;
    if (err_q) begin
      fetch_resp = RespSlverr;
    end else if (!addr_hit(fetch_addr)) begin
      fetch_resp = RespDecerr;
    end else begin
      fetch_resp = RespOkay;
    end
    fetch_data = (fetch_resp == RespOkay) ? mem[addr_idx(fetch_addr)] : 32'd0;
  end

  // Next-state and registered output logic.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    len_d    = len_q;
    burst_d  = burst_q;
    id_d     = id_q;
    addr_d   = addr_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;

    case (state_q)
      StIdle: begin
        if (axi_arvalid_i && arready_q) begin
          state_d = StLat;
          lat_d   = LatInit;
          beat_d  = 8'd0;
          len_d   = axi_arlen_i;
          burst_d = axi_arburst_i;
          id_d    = axi_arid_i;
          addr_d  = axi_araddr_i & ~32'h3;
          err_d   = (axi_arburst_i == 2'b11) ||
                    ((axi_arburst_i == 2'b10) && !((axi_arlen_i == 8'd1) ||
                     (axi_arlen_i == 8'd3) || (axi_arlen_i == 8'd7) || (axi_arlen_i == 8'd15)));
        end
      end
      StLat: begin
        if (lat_q == 4'd0) begin
          state_d  = StData;
          rvalid_d = 1'b1;
          rdata_d  = fetch_data;
          rresp_d  = fetch_resp;
          rlast_d  = (len_q == 8'd0);
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StData: begin
        if (rvalid_q && axi_rready_i) begin
          if (rlast_q) begin
            state_d  = StIdle;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            addr_d   = next_addr;
            beat_d   = 8'(beat_q + 8'd1);
            rvalid_d = !stall;
            rdata_d  = fetch_data;
            rresp_d  = fetch_resp;
            rlast_d  = (8'(beat_q + 8'd1) == len_q);
          end
        end else if (!rvalid_q) begin
          // Withheld beat is already fetched; present it now.
          rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    arready_d = (state_d == StIdle) && !init_we_i;
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      lat_q     <= 4'd0;
      beat_q    <= 8'd0;
      len_q     <= 8'd0;
      burst_q   <= 2'b00;
      id_q      <= 4'd0;
      addr_q    <= 32'd0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign axi_arready_o = arready_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = rresp_q;
  assign axi_rid_o     = id_q;
  assign axi_rlast_o   = rlast_q;

endmodule
